keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 14 +
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/keypad_scanner.sv | 171 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states and seven-segment glyph table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

  // Active-low {g,f,e,d,c,b,a} glyphs; index 15 is the leftmost entry
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0e, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low seven-segment glyph.
// Latency: combinational.
// Backpressure: none.
module seg7_hex_decoder import keypad_pkg::*; (
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  assign segs = SEG_GLYPH[hex];

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with debounce and one-deep key handshake; KEYPAD_SEG_EN adds a 7-seg digit.
// Latency: 2-cycle row synchronizer, SCAN_DIV per column, DEBOUNCE_CNT to accept; segs/en 1 cycle after key.
// Backpressure: key held until key_ready; a key accepted while one is pending is dropped and sets overflow.
module keypad_scanner import keypad_pkg::*; #(
  parameter  int ROWS         = 4,
  parameter  int COLS         = 4,
  parameter  int SCAN_DIV     = 1000,
  parameter  int DEBOUNCE_CNT = 10000,
  localparam int KW           = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            overflow
`ifdef KEYPAD_SEG_EN
  ,
  output logic [6:0]      segs,
  output logic            en
`endif
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_CNT - 1);

  kp_state_t       state, state_nxt;
  logic [ROWS-1:0] row_s1, row_s2, latch, latch_nxt;
  logic [CW-1:0]   col_idx, col_idx_nxt, col_inc;
  logic [DW-1:0]   div_cnt, div_cnt_nxt;
  logic [BW-1:0]   deb_cnt, deb_cnt_nxt;
  logic [KW-1:0]   key_code_nxt, hit_code;
  logic            key_valid_nxt, overflow_nxt, accept, all_high, hs_done;

  assign all_high = &row_s2;
  assign col_inc  = (col_idx == COL_LAST) ? '0 : col_idx + CW'(1);
  assign col      = ~(COLS'(1) << col_idx);
  assign hs_done  = key_valid & key_ready;

  // Lowest-index low row of the debounced pattern wins
  always_comb begin
    hit_code = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (!latch[i]) hit_code = KW'(int'(col_idx) * ROWS + i);
  end

  always_comb begin
    state_nxt     = state;
    col_idx_nxt   = col_idx;
    div_cnt_nxt   = div_cnt;
    deb_cnt_nxt   = deb_cnt;
    latch_nxt     = latch;
    accept        = 1'b0;
    key_valid_nxt = key_valid & ~hs_done;
    key_code_nxt  = key_code;
    overflow_nxt  = overflow;
    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (all_high) begin
            col_idx_nxt = col_inc;
          end else begin
            latch_nxt   = row_s2;
            deb_cnt_nxt = '0;
            state_nxt   = DEBOUNCE;
          end
        end else begin
          div_cnt_nxt = div_cnt + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (all_high) begin
          state_nxt   = SCAN;
          col_idx_nxt = col_inc;
          div_cnt_nxt = '0;
        end else if (row_s2 != latch) begin
          latch_nxt   = row_s2;
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          accept    = 1'b1;
          state_nxt = HELD;
        end else begin
          deb_cnt_nxt = deb_cnt + BW'(1);
        end
      end
      HELD: begin
        if (all_high) begin
          state_nxt   = RELEASE;
          deb_cnt_nxt = '0;
        end
      end
      RELEASE: begin
        if (!all_high) begin
          state_nxt = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = SCAN;
          col_idx_nxt = col_inc;
          div_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + BW'(1);
        end
      end
      default: state_nxt = SCAN;
    endcase
    // A handshake completing this cycle frees the slot for the new key
    if (accept) begin
      if (!key_valid || hs_done) begin
        key_valid_nxt = 1'b1;
        key_code_nxt  = hit_code;
      end else begin
        overflow_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      row_s1    <= '1;
      row_s2    <= '1;
      latch     <= '1;
      col_idx   <= '0;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      row_s1    <= row;
      row_s2    <= row_s1;
      latch     <= latch_nxt;
      col_idx   <= col_idx_nxt;
      div_cnt   <= div_cnt_nxt;
      deb_cnt   <= deb_cnt_nxt;
      key_code  <= key_code_nxt;
      key_valid <= key_valid_nxt;
      overflow  <= overflow_nxt;
    end
  end

`ifdef KEYPAD_SEG_EN
  logic [6:0] glyph;
  logic       seen;

  seg7_hex_decoder u_dec (
    .hex  (4'(key_code)),
    .segs (glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen <= 1'b0;
      segs <= '1;
      en   <= 1'b1;
    end else begin
      if (key_valid) seen <= 1'b1;
      segs <= (key_valid || seen) ? glyph : '1;
      en   <= ~(key_valid || seen);
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key-press table, randomized press/release against a scoreboard, corner sequences.
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;
`ifdef KEYPAD_SEG_EN
  logic [6:0] segs;
  logic       en;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   got_q[$];
  int   exp_q[$];
  logic key_down  = 1'b0;
  int   pr        = 0;
  int   pc        = 0;
  logic rand_mode = 1'b0;
  logic ready_set = 1'b1;
  logic rnd_ready = 1'b1;

  typedef struct { int r; int c; int code; } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  // Keypad model: a pressed switch pulls its row low only while its column is driven low
  assign row       = (key_down && !col[pc]) ? ~(4'(1) << pr) : 4'hF;
  assign key_ready = rand_mode ? rnd_ready : ready_set;

  always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));

  always @(negedge clk)
    if (!rst && key_valid && key_ready) got_q.push_back(int'(key_code));

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_CNT(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow)
`ifdef KEYPAD_SEG_EN
    ,
    .segs      (segs),
    .en        (en)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_col_leave(input logic [3:0] from, input int max);
    int k = 0;
    while (col == from && k < max) begin tick(1); k++; end
  endtask

  task automatic wait_col_reach(input logic [3:0] to, input int max);
    int k = 0;
    while (col != to && k < max) begin tick(1); k++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, act;

    vecs[0] = '{2, 1, 6};  vecs[1] = '{1, 1, 5};  vecs[2] = '{1, 2, 9};  vecs[3] = '{3, 3, 15};
    vecs[4] = '{0, 0, 0};  vecs[5] = '{2, 2, 10}; vecs[6] = '{3, 0, 3};  vecs[7] = '{0, 3, 12};

    rst = 1'b1;
    tick(3);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_key_code", int'(key_code), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_col", int'(col), 4'b1110);
    rst = 1'b0;
    tick(2);

    // One key per press regardless of hold length; nothing more until release
    foreach (vecs[i]) begin
      n0 = got_q.size();
      pr = vecs[i].r; pc = vecs[i].c; key_down = 1'b1;
      tick(60);
      check($sformatf("vec%0d_keys_held", i), got_q.size() - n0, 1);
      act = (got_q.size() > n0) ? got_q[n0] : -1;
      check($sformatf("vec%0d_code", i), act, vecs[i].code);
      key_down = 1'b0;
      tick(60);
      check($sformatf("vec%0d_keys_released", i), got_q.size() - n0, 1);
    end

    // Glitch shorter than the debounce window on column 0
    n0 = got_q.size();
    wait_col_leave(4'b1110, 40);
    wait_col_reach(4'b1110, 40);
    pr = 0; pc = 0; key_down = 1'b1;
    tick(3);
    key_down = 1'b0;
    wait_col_leave(4'b1110, 40);
    check("glitch_next_col", int'(col), 4'b1101);
    tick(60);
    check("glitch_no_key", got_q.size() - n0, 0);

    // Column 3 / row 3: column held while pressed, then scan wraps to column 0
    n0 = got_q.size();
    pr = 3; pc = 3; key_down = 1'b1;
    tick(60);
    act = (got_q.size() > n0) ? got_q[n0] : -1;
    check("c3r3_code", act, 15);
    check("c3r3_col_held", int'(col), 4'b0111);
    key_down = 1'b0;
    wait_col_leave(4'b0111, 40);
    check("c3r3_wrap_col", int'(col), 4'b1110);

    // Randomized presses with a random consumer; model: each press yields col*ROWS+row
    rand_mode = 1'b1;
    n0 = got_q.size();
    for (int i = 0; i < 12; i++) begin
      pr = $urandom_range(0, ROWS - 1);
      pc = $urandom_range(0, COLS - 1);
      exp_q.push_back(pc * ROWS + pr);
      key_down = 1'b1;
      tick($urandom_range(45, 90));
      key_down = 1'b0;
      tick($urandom_range(45, 90));
    end
    tick(20);
    rand_mode = 1'b0;
    check("rand_key_count", got_q.size() - n0, exp_q.size());
    foreach (exp_q[i]) begin
      act = (got_q.size() > n0 + i) ? got_q[n0 + i] : -1;
      check($sformatf("rand_code%0d", i), act, exp_q[i]);
    end
    check("rand_overflow", int'(overflow), 0);

    // Stalled consumer: second key is dropped, first stays visible
    ready_set = 1'b0;
    pr = 1; pc = 1; key_down = 1'b1; tick(50);
    key_down = 1'b0; tick(50);
    pr = 1; pc = 2; key_down = 1'b1; tick(50);
    key_down = 1'b0; tick(50);
    check("stall_key_valid", int'(key_valid), 1);
    check("stall_key_code", int'(key_code), 5);
    check("stall_overflow", int'(overflow), 1);
    ready_set = 1'b1;
    tick(1);
    check("stall_valid_drop", int'(key_valid), 0);
    tick(20);
    check("stall_overflow_sticky", int'(overflow), 1);

    // Reset in the middle of debouncing a press on column 2
    wait_col_leave(4'b1011, 40);
    wait_col_reach(4'b1011, 40);
    pr = 0; pc = 2; key_down = 1'b1;
    tick(6);
    rst = 1'b1;
    tick(1);
    check("midrst_key_valid", int'(key_valid), 0);
    check("midrst_col", int'(col), 4'b1110);
    check("midrst_overflow", int'(overflow), 0);
    key_down = 1'b0;
    tick(2);
    rst = 1'b0;
    n0 = got_q.size();
    tick(100);
    check("midrst_no_emit", got_q.size() - n0, 0);
    check("midrst_valid_after", int'(key_valid), 0);

`ifdef KEYPAD_SEG_EN
    check("seg_blank", int'(segs), 7'h7f);
    check("seg_en_off", int'(en), 1);
    begin
      int k = 0;
      pr = 2; pc = 2; key_down = 1'b1;
      while (!key_valid && k < 80) begin tick(1); k++; end
      check("seg_key_seen", int'(key_valid), 1);
      tick(1);
      check("seg_glyph_A", int'(segs), 7'h08);
      check("seg_en_on", int'(en), 0);
      key_down = 1'b0;
      tick(40);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
